dlart_mux: RTL and testbench
============================

# dlart_mux

Parametrised multi-channel DL11-style console bridge between the DCJ11 bus decoder and the Apple II slot interface. Replaces the single-byte, strobe-handshake console path with NCH independent channels, each holding a receive FIFO (Apple → PDP-11) and a transmit FIFO (PDP-11 → Apple). It adds per-channel interrupt enables, receive-overrun reporting and a prioritised interrupt vector output. It sits behind the bus-cycle decoder in the 18 MHz `clk` domain; both sides present pre-decoded, single-cycle access strobes.

## Interface
Parameters:
- NCH, 1, number of channels (1..4)
- DEPTH, 8, FIFO depth per direction, power of two (2..16)
- VEC_BASE, 9'o060, vector of channel 0 RX; TX is +4; channel n ≥ 1 uses 9'o300 + 8·(n−1) RX, +4 TX

Ports:
- clk  in  1  system clock; all state on posedge
- rst_n  in  1  asynchronous active-low reset
- bus_init  in  1  synchronous clear (bus INIT, GP code 014)
- cpu_sel  in  1  one-cycle CPU register access strobe
- cpu_wr  in  1  1 = write, 0 = read
- cpu_ch  in  2  channel index
- cpu_reg  in  2  0 RCSR, 1 RBUF, 2 XCSR, 3 XBUF
- cpu_wdata  in  16  write data
- cpu_rdata  out  16  read data (combinational)
- a2_sel  in  1  one-cycle Apple access strobe (already synchronised)
- a2_rw  in  1  1 = Apple read, 0 = Apple write
- a2_addr  in  4  [3:2] channel, [1:0] register
- a2_wdata  in  8  Apple write data
- a2_rdata  out  8  Apple read data (combinational)
- irq_req  out  1  any enabled channel condition pending
- irq_vec  out  9  vector of highest-priority pending source

## Operation
- CPU RCSR: bit7 DONE = RX FIFO non-empty (RO), bit6 RIE (RW); other bits read 0.
- CPU RBUF read: {ERR, OVR, 6'b0, head byte}; pops RX FIFO if non-empty; clears OVR. ERR = OVR. Empty read returns head field 0, no pop.
- CPU XCSR: bit7 READY = TX FIFO not full (RO), bit6 TIE (RW).
- CPU XBUF write: pushes cpu_wdata[7:0]; dropped silently when full. XBUF reads 0.
- Apple reg 0 STATUS (RO): bit7 TX data available, bit6 RX space available, bits[4:0] TX count.
- Apple reg 1 TXDATA read: head of TX FIFO, pops if non-empty, else 0.
- Apple reg 2 RXDATA write: pushes into RX FIFO; when full, data is dropped and OVR is set (sticky).
- Apple reg 3 reads 0; writes are ignored.
- Channel index ≥ NCH: reads 0, writes ignored, no FIFO effect.
- Interrupt sources: RX = RIE & DONE, TX = TIE & READY, both level. Priority: lowest channel first, RX before TX within a channel. irq_vec = 0 when irq_req = 0.

## Timing
- Reset (rst_n low, asynchronous): all FIFOs empty, pointers 0, RIE/TIE/OVR 0. Outputs: cpu_rdata 0, a2_rdata 0, irq_req 0, irq_vec 0. Consequently, after reset every XCSR READY = 1 (TX FIFO empty, not full).
- bus_init: same clear as reset on the next posedge. It overrides any access strobe in the same cycle.
- Read data is valid in the strobe cycle, from pre-edge state. Pop and pointer advance take effect at the closing posedge.
- Push is visible (DONE / TX available) the cycle after the strobe.
- CPU and Apple accesses in the same cycle are both performed, including push and pop on one FIFO. Push+pop on a full FIFO succeeds, with the count unchanged. Push+pop on an empty FIFO: the pop is ignored and the push lands.
- Pointers are log2(DEPTH) bits and wrap naturally. The count is log2(DEPTH)+1 bits. Full when count == DEPTH.
- irq_req/irq_vec are combinational from registered state: at most one cycle after the causing edge.

## Structure
- dlart_pkg: register index constants, CSR bit positions, VEC_BASE/alt-base constants, `typedef` for channel state.
- Sub-module sync_fifo (WIDTH=8, DEPTH): push, pop, full, empty, count, head data, sync clear. Instantiated 2·NCH times via a generate loop.
- Top: per-channel CSR flops, access decode, read muxes, priority encoder.

## Test plan
- Reset, then CPU reads XCSR ch0 → 16'o000200. RCSR → 0. irq_req = 0.
- Apple writes 8'h41 to RXDATA ch1 → ch1 RCSR DONE = 1 next cycle. With RIE set, irq_vec = 9'o300. RBUF read → 16'h0041, then DONE = 0.
- CPU writes DEPTH+1 bytes to XBUF ch0 → READY drops after the DEPTH-th write. Apple STATUS count = DEPTH. TXDATA pops return bytes in order; the extra byte is absent.
- Apple writes DEPTH+1 bytes to RXDATA ch2 → RBUF first read = 16'hC000 | byte0. The second read has ERR/OVR = 0.
- Same-cycle CPU XBUF push and Apple TXDATA pop on a full FIFO → count stays DEPTH, and the popped byte is the oldest.
- RIE ch0 and TIE ch0 set, both pending → irq_vec = 9'o060. A bus_init pulse mid-traffic empties all FIFOs and clears irq_req next cycle.

Source files
------------

// File: rtl/dlart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dlart_pkg
//  Brief    : Shared constants, channel state type and vector helper for dlart_mux
//  Revision : 1.0
// ============================================================================
package dlart_pkg;

    // CPU register indices
    localparam logic [1:0] c_REG_RCSR = 2'd0;
    localparam logic [1:0] c_REG_RBUF = 2'd1;
    localparam logic [1:0] c_REG_XCSR = 2'd2;
    localparam logic [1:0] c_REG_XBUF = 2'd3;

    // Apple register indices
    localparam logic [1:0] c_A2_STATUS = 2'd0;
    localparam logic [1:0] c_A2_TXDATA = 2'd1;
    localparam logic [1:0] c_A2_RXDATA = 2'd2;

    // CSR / RBUF bit positions
    localparam int c_BIT_DONE = 7;
    localparam int c_BIT_IE   = 6;
    localparam int c_BIT_ERR  = 15;
    localparam int c_BIT_OVR  = 14;

    localparam logic [8:0] c_VEC_BASE_DEF = 9'o060;
    localparam logic [8:0] c_VEC_ALT_BASE = 9'o300;

    typedef struct packed {
        logic rie;
        logic tie;
        logic ovr;
    } chan_state_t;

    // Channel 0 keeps the classic console vector; later channels use the alternate block
    function automatic logic [8:0] chan_vec(input logic [8:0] base, input int ch, input logic tx);
        logic [8:0] v;
        if (ch == 0) v = base;
        else         v = c_VEC_ALT_BASE + 9'(8 * (ch - 1));
        return v + (tx ? 9'd4 : 9'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo
//  Brief    : Single-clock FIFO with simultaneous push/pop and synchronous clear
//  Revision : 1.0
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    input  logic                      push,
    input  logic                      pop,
    input  logic [WIDTH-1:0]          din,
    output logic [WIDTH-1:0]          dout,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);
    localparam int c_PW = $clog2(DEPTH);
    localparam int c_CW = c_PW + 1;
    localparam logic [c_CW-1:0] c_DEPTH_CNT = c_CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_PW-1:0]  r_wptr;
    logic [c_PW-1:0]  r_rptr;
    logic [c_CW-1:0]  r_count;
    logic             w_pop_eff;
    logic             w_push_eff;

    assign full  = (r_count == c_DEPTH_CNT);
    assign empty = (r_count == '0);
    assign count = r_count;
    assign dout  = r_mem[r_rptr];

    // A pop frees a slot in the same edge, so push into a full FIFO succeeds alongside it
    assign w_pop_eff  = pop & ~empty & ~clr;
    assign w_push_eff = push & (~full | w_pop_eff) & ~clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (clr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_eff) r_wptr <= r_wptr + c_PW'(1);
            if (w_pop_eff)  r_rptr <= r_rptr + c_PW'(1);
            case ({w_push_eff, w_pop_eff})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_eff) r_mem[r_wptr] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/dlart_mux.sv
`default_nettype none
// ============================================================================
//  Module   : dlart_mux
//  Brief    : Multi-channel DL11-style console bridge between DCJ11 and Apple II
//  Revision : 1.0
// ============================================================================
module dlart_mux
    import dlart_pkg::*;
#(
    parameter int         NCH      = 1,
    parameter int         DEPTH    = 8,
    parameter logic [8:0] VEC_BASE = c_VEC_BASE_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bus_init,
    input  logic        cpu_sel,
    input  logic        cpu_wr,
    input  logic [1:0]  cpu_ch,
    input  logic [1:0]  cpu_reg,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    input  logic        a2_sel,
    input  logic        a2_rw,
    input  logic [3:0]  a2_addr,
    input  logic [7:0]  a2_wdata,
    output logic [7:0]  a2_rdata,
    output logic        irq_req,
    output logic [8:0]  irq_vec
);
    localparam int c_CW = $clog2(DEPTH) + 1;
    localparam logic [c_CW-1:0] c_DEPTH_CNT = c_CW'(DEPTH);

    logic           w_cpu_acc;
    logic           w_a2_acc;
    logic [1:0]     w_a2_ch;
    logic [1:0]     w_a2_reg;
    logic [15:0]    w_cpu_rd_ch [NCH];
    logic [7:0]     w_a2_rd_ch  [NCH];
    logic [NCH-1:0] w_rx_irq;
    logic [NCH-1:0] w_tx_irq;
    logic           w_unused_ok;

    // bus_init wins over any strobe presented in the same cycle
    assign w_cpu_acc   = cpu_sel & ~bus_init;
    assign w_a2_acc    = a2_sel & ~bus_init;
    assign w_a2_ch     = a2_addr[3:2];
    assign w_a2_reg    = a2_addr[1:0];
    assign w_unused_ok = &{1'b0, cpu_wdata[15:8]};

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        chan_state_t     r_st;
        logic            w_cpu_hit, w_a2_hit;
        logic            w_rx_push, w_rx_pop, w_rx_full, w_rx_empty;
        logic            w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;
        logic [7:0]      w_rx_head, w_tx_head;
        logic [c_CW-1:0] w_rx_count, w_tx_count;
        logic            w_ovr_set;
        logic [15:0]     w_cpu_rd;
        logic [7:0]      w_a2_rd;

        assign w_cpu_hit = w_cpu_acc && (cpu_ch == 2'(g));
        assign w_a2_hit  = w_a2_acc && (w_a2_ch == 2'(g));

        assign w_rx_push = w_a2_hit && !a2_rw && (w_a2_reg == c_A2_RXDATA);
        assign w_rx_pop  = w_cpu_hit && !cpu_wr && (cpu_reg == c_REG_RBUF);
        assign w_tx_push = w_cpu_hit && cpu_wr && (cpu_reg == c_REG_XBUF);
        assign w_tx_pop  = w_a2_hit && a2_rw && (w_a2_reg == c_A2_TXDATA);

        // Overrun only when the byte is really lost, not when a same-cycle pop makes room
        assign w_ovr_set = w_rx_push & w_rx_full & ~w_rx_pop;

        sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
            .clk   (clk),        .rst_n (rst_n),      .clr   (bus_init),
            .push  (w_rx_push),  .pop   (w_rx_pop),   .din   (a2_wdata),
            .dout  (w_rx_head),  .full  (w_rx_full),  .empty (w_rx_empty),
            .count (w_rx_count)
        );

        sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
            .clk   (clk),        .rst_n (rst_n),      .clr   (bus_init),
            .push  (w_tx_push),  .pop   (w_tx_pop),   .din   (cpu_wdata[7:0]),
            .dout  (w_tx_head),  .full  (w_tx_full),  .empty (w_tx_empty),
            .count (w_tx_count)
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_st <= '0;
            end else if (bus_init) begin
                r_st <= '0;
            end else begin
                if (w_cpu_hit && cpu_wr && cpu_reg == c_REG_RCSR) r_st.rie <= cpu_wdata[c_BIT_IE];
                if (w_cpu_hit && cpu_wr && cpu_reg == c_REG_XCSR) r_st.tie <= cpu_wdata[c_BIT_IE];
                r_st.ovr <= (r_st.ovr & ~w_rx_pop) | w_ovr_set;
            end
        end

        always_comb begin
            w_cpu_rd = '0;
            if (w_cpu_hit && !cpu_wr) begin
                case (cpu_reg)
                    c_REG_RCSR: begin
                        w_cpu_rd[c_BIT_DONE] = ~w_rx_empty;
                        w_cpu_rd[c_BIT_IE]   = r_st.rie;
                    end
                    c_REG_RBUF: begin
                        w_cpu_rd[c_BIT_ERR] = r_st.ovr;
                        w_cpu_rd[c_BIT_OVR] = r_st.ovr;
                        w_cpu_rd[7:0]       = w_rx_empty ? 8'h00 : w_rx_head;
                    end
                    c_REG_XCSR: begin
                        w_cpu_rd[c_BIT_DONE] = ~w_tx_full;
                        w_cpu_rd[c_BIT_IE]   = r_st.tie;
                    end
                    default: w_cpu_rd = '0;
                endcase
            end
        end

        always_comb begin
            w_a2_rd = '0;
            if (w_a2_hit && a2_rw) begin
                case (w_a2_reg)
                    c_A2_STATUS: w_a2_rd = {~w_tx_empty, (w_rx_count != c_DEPTH_CNT), 1'b0, 5'(w_tx_count)};
                    c_A2_TXDATA: w_a2_rd = w_tx_empty ? 8'h00 : w_tx_head;
                    default:     w_a2_rd = '0;
                endcase
            end
        end

        assign w_cpu_rd_ch[g] = w_cpu_rd;
        assign w_a2_rd_ch[g]  = w_a2_rd;
        assign w_rx_irq[g]    = r_st.rie & ~w_rx_empty;
        assign w_tx_irq[g]    = r_st.tie & ~w_tx_full;
    end

    // Unaddressed channels contribute zero, so OR-combining acts as the read mux
    always_comb begin
        cpu_rdata = '0;
        a2_rdata  = '0;
        for (int i = 0; i < NCH; i++) begin
            cpu_rdata = cpu_rdata | w_cpu_rd_ch[i];
            a2_rdata  = a2_rdata | w_a2_rd_ch[i];
        end
    end

    always_comb begin
        irq_req = |{w_rx_irq, w_tx_irq};
        irq_vec = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (w_tx_irq[i]) irq_vec = chan_vec(VEC_BASE, i, 1'b1);
            if (w_rx_irq[i]) irq_vec = chan_vec(VEC_BASE, i, 1'b0);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dlart_mux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dlart_mux
//  Brief    : Self-checking bench for dlart_mux against a queue-based model
//  Revision : 1.0
// ============================================================================
module tb_dlart_mux;
    localparam int NCH   = 4;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bus_init = 1'b0;
    logic        cpu_sel = 1'b0;
    logic        cpu_wr = 1'b0;
    logic [1:0]  cpu_ch = '0;
    logic [1:0]  cpu_reg = '0;
    logic [15:0] cpu_wdata = '0;
    logic [15:0] cpu_rdata;
    logic        a2_sel = 1'b0;
    logic        a2_rw = 1'b0;
    logic [3:0]  a2_addr = '0;
    logic [7:0]  a2_wdata = '0;
    logic [7:0]  a2_rdata;
    logic        irq_req;
    logic [8:0]  irq_vec;

    always #5 clk = ~clk;

    dlart_mux #(.NCH(NCH), .DEPTH(DEPTH), .VEC_BASE(9'o060)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus_init  (bus_init),
        .cpu_sel   (cpu_sel),
        .cpu_wr    (cpu_wr),
        .cpu_ch    (cpu_ch),
        .cpu_reg   (cpu_reg),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .a2_sel    (a2_sel),
        .a2_rw     (a2_rw),
        .a2_addr   (a2_addr),
        .a2_wdata  (a2_wdata),
        .a2_rdata  (a2_rdata),
        .irq_req   (irq_req),
        .irq_vec   (irq_vec)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: plain byte queues and flag arrays per channel
    logic [7:0]  rxq [NCH][$];
    logic [7:0]  txq [NCH][$];
    bit          m_rie [NCH];
    bit          m_tie [NCH];
    bit          m_ovr [NCH];

    logic [15:0] last_cpu;
    logic [7:0]  last_a2;
    logic        last_req;
    logic [8:0]  last_vec;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] vec_of(input int ch, input bit tx);
        int v;
        v = (ch == 0) ? 'o60 : ('o300 + 8 * (ch - 1));
        if (tx) v = v + 4;
        return 9'(v);
    endfunction

    function automatic logic [15:0] exp_cpu(input int ch, input int r);
        logic [15:0] v;
        v = '0;
        if (ch < NCH) begin
            case (r)
                0: v = {8'h00, rxq[ch].size() != 0, m_rie[ch], 6'b0};
                1: v = {m_ovr[ch], m_ovr[ch], 6'b0, (rxq[ch].size() != 0) ? rxq[ch][0] : 8'h00};
                2: v = {8'h00, txq[ch].size() < DEPTH, m_tie[ch], 6'b0};
                default: v = '0;
            endcase
        end
        return v;
    endfunction

    function automatic logic [7:0] exp_a2(input int ch, input int r);
        logic [7:0] v;
        v = '0;
        if (ch < NCH) begin
            case (r)
                0: v = {txq[ch].size() != 0, rxq[ch].size() < DEPTH, 1'b0, 5'(txq[ch].size())};
                1: v = (txq[ch].size() != 0) ? txq[ch][0] : 8'h00;
                default: v = '0;
            endcase
        end
        return v;
    endfunction

    // First pending source scanning channels upward, RX before TX
    task automatic exp_irq(output bit req, output logic [8:0] vec);
        bit found;
        found = 1'b0;
        vec   = '0;
        for (int c = 0; c < NCH; c++) begin
            if (!found && m_rie[c] && rxq[c].size() > 0) begin
                found = 1'b1; vec = vec_of(c, 1'b0);
            end
            if (!found && m_tie[c] && txq[c].size() < DEPTH) begin
                found = 1'b1; vec = vec_of(c, 1'b1);
            end
        end
        req = found;
    endtask

    task automatic model_clear();
        for (int c = 0; c < NCH; c++) begin
            rxq[c].delete();
            txq[c].delete();
            m_rie[c] = 1'b0;
            m_tie[c] = 1'b0;
            m_ovr[c] = 1'b0;
        end
    endtask

    task automatic model_update(input bit cs, input bit cw, input int cch, input int creg,
                                input logic [15:0] cwd, input bit as, input bit arw,
                                input int ach, input int areg, input logic [7:0] awd);
        bit rx_pop [NCH];
        bit rx_push [NCH];
        bit tx_pop [NCH];
        bit tx_push [NCH];
        bit p_ok, w_ok;
        for (int c = 0; c < NCH; c++) begin
            rx_pop[c] = 0; rx_push[c] = 0; tx_pop[c] = 0; tx_push[c] = 0;
        end
        if (cs && cch < NCH) begin
            if (cw) begin
                if (creg == 0) m_rie[cch] = cwd[6];
                if (creg == 2) m_tie[cch] = cwd[6];
                if (creg == 3) tx_push[cch] = 1;
            end else if (creg == 1) begin
                rx_pop[cch] = 1;
                m_ovr[cch]  = 1'b0;
            end
        end
        if (as && ach < NCH) begin
            if (arw && areg == 1)  tx_pop[ach]  = 1;
            if (!arw && areg == 2) rx_push[ach] = 1;
        end
        for (int c = 0; c < NCH; c++) begin
            p_ok = rx_pop[c] && rxq[c].size() > 0;
            w_ok = rx_push[c] && (rxq[c].size() < DEPTH || p_ok);
            if (rx_push[c] && !w_ok) m_ovr[c] = 1'b1;
            if (p_ok) void'(rxq[c].pop_front());
            if (w_ok) rxq[c].push_back(awd);
            p_ok = tx_pop[c] && txq[c].size() > 0;
            w_ok = tx_push[c] && (txq[c].size() < DEPTH || p_ok);
            if (p_ok) void'(txq[c].pop_front());
            if (w_ok) txq[c].push_back(cwd[7:0]);
        end
    endtask

    task automatic step(input bit cs, input bit cw, input int cch, input int creg,
                        input logic [15:0] cwd, input bit as, input bit arw,
                        input int ach, input int areg, input logic [7:0] awd, input bit init);
        bit         e_req;
        logic [8:0] e_vec;
        cpu_sel = cs; cpu_wr = cw; cpu_ch = 2'(cch); cpu_reg = 2'(creg); cpu_wdata = cwd;
        a2_sel = as; a2_rw = arw; a2_addr = {2'(ach), 2'(areg)}; a2_wdata = awd;
        bus_init = init;
        @(negedge clk);
        last_cpu = cpu_rdata; last_a2 = a2_rdata; last_req = irq_req; last_vec = irq_vec;
        if (cs && !cw && !init) chk("cpu_rdata", cpu_rdata, exp_cpu(cch, creg));
        if (as && arw && !init) chk("a2_rdata", {8'h00, a2_rdata}, {8'h00, exp_a2(ach, areg)});
        exp_irq(e_req, e_vec);
        chk("irq_req", {15'h0, irq_req}, {15'h0, e_req});
        chk("irq_vec", {7'h0, irq_vec}, {7'h0, e_vec});
        @(posedge clk);
        if (init) model_clear();
        else      model_update(cs, cw, cch, creg, cwd, as, arw, ach, areg, awd);
        #1;
        cpu_sel = 1'b0; a2_sel = 1'b0; bus_init = 1'b0;
    endtask

    task automatic idle();                                         step(0, 0, 0, 0, 16'h0, 0, 0, 0, 0, 8'h0, 0); endtask
    task automatic crd(input int ch, input int r);                 step(1, 0, ch, r, 16'h0, 0, 0, 0, 0, 8'h0, 0); endtask
    task automatic cwrt(input int ch, input int r, input logic [15:0] d); step(1, 1, ch, r, d, 0, 0, 0, 0, 8'h0, 0); endtask
    task automatic ard(input int ch, input int r);                 step(0, 0, 0, 0, 16'h0, 1, 1, ch, r, 8'h0, 0); endtask
    task automatic awrt(input int ch, input int r, input logic [7:0] d);  step(0, 0, 0, 0, 16'h0, 1, 0, ch, r, d, 0); endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cpu_rdata", cpu_rdata, 16'h0);
        chk("rst_a2_rdata", {8'h00, a2_rdata}, 16'h0);
        chk("rst_irq_req", {15'h0, irq_req}, 16'h0);
        chk("rst_irq_vec", {7'h0, irq_vec}, 16'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        crd(0, 2);
        chk("xcsr_after_reset", last_cpu, 16'o000200);
        crd(0, 0);
        chk("rcsr_after_reset", last_cpu, 16'h0000);

        // Apple byte into channel 1, interrupt on RX
        awrt(1, 2, 8'h41);
        crd(1, 0);
        chk("ch1_done", last_cpu, 16'h0080);
        cwrt(1, 0, 16'h0040);
        idle();
        chk("ch1_rx_vec", {7'h0, last_vec}, {7'h0, 9'o300});
        crd(1, 1);
        chk("ch1_rbuf", last_cpu, 16'h0041);
        crd(1, 0);
        chk("ch1_done_clear", last_cpu, 16'h0040);
        cwrt(1, 0, 16'h0000);

        // TX fill past depth on channel 0
        for (int i = 0; i < DEPTH - 1; i++) cwrt(0, 3, 16'(16'h10 + i));
        crd(0, 2);
        chk("ready_before_full", last_cpu, 16'h0080);
        cwrt(0, 3, 16'(16'h10 + DEPTH - 1));
        crd(0, 2);
        chk("ready_at_full", last_cpu, 16'h0000);
        cwrt(0, 3, 16'h00EE);
        ard(0, 0);
        chk("status_count_full", {11'h0, last_a2[4:0]}, 16'(DEPTH));
        ard(0, 1);
        chk("first_tx_pop", {8'h00, last_a2}, 16'h0010);
        for (int i = 1; i < DEPTH; i++) ard(0, 1);
        ard(0, 1);
        chk("tx_extra_absent", {8'h00, last_a2}, 16'h0000);

        // RX overrun on channel 2
        for (int i = 0; i <= DEPTH; i++) awrt(2, 2, 8'(8'hA0 + i));
        crd(2, 1);
        chk("rbuf_overrun", last_cpu, 16'hC0A0);
        crd(2, 1);
        chk("rbuf_after_ovr", last_cpu, 16'h00A1);
        for (int i = 2; i <= DEPTH; i++) crd(2, 1);

        // Simultaneous push and pop on a full TX FIFO
        for (int i = 0; i < DEPTH; i++) cwrt(3, 3, 16'(16'h30 + i));
        step(1, 1, 3, 3, 16'h0055, 1, 1, 3, 1, 8'h00, 0);
        chk("full_pushpop_head", {8'h00, last_a2}, 16'h0030);
        ard(3, 0);
        chk("full_pushpop_count", {11'h0, last_a2[4:0]}, 16'(DEPTH));
        for (int i = 0; i < DEPTH; i++) ard(3, 1);
        chk("full_pushpop_last", {8'h00, last_a2}, 16'h0055);

        // Simultaneous push and pop on an empty RX FIFO
        step(1, 0, 1, 1, 16'h0, 1, 0, 1, 2, 8'h5A, 0);
        chk("empty_pushpop_rd", last_cpu, 16'h0000);
        crd(1, 1);
        chk("empty_pushpop_land", last_cpu, 16'h005A);

        // Channel 0 RX and TX both pending, then bus_init mid-traffic
        cwrt(0, 0, 16'h0040);
        cwrt(0, 2, 16'h0040);
        awrt(0, 2, 8'h77);
        idle();
        chk("ch0_vec", {7'h0, last_vec}, {7'h0, 9'o060});
        cwrt(1, 3, 16'h0011);
        awrt(2, 2, 8'h22);
        step(1, 1, 3, 3, 16'h0033, 1, 0, 1, 2, 8'h44, 1);
        idle();
        chk("init_irq_clear", {15'h0, last_req}, 16'h0);
        ard(1, 0);
        chk("init_status", {8'h00, last_a2}, 16'h0040);
        crd(0, 2);
        chk("init_xcsr", last_cpu, 16'h0080);

        // Randomised traffic: push-heavy, pop-heavy, then balanced
        for (int i = 0; i < 600; i++) begin
            int ph, cch, creg, ach, areg;
            bit cs, cw, as, arw, init;
            ph   = i / 200;
            cs   = $urandom_range(0, 3) != 0;
            as   = $urandom_range(0, 3) != 0;
            cch  = int'($urandom_range(0, 3));
            ach  = int'($urandom_range(0, 3));
            creg = int'($urandom_range(0, 3));
            areg = int'($urandom_range(0, 3));
            case (ph)
                0: begin
                    cw  = $urandom_range(0, 4) != 0;
                    arw = $urandom_range(0, 4) == 0;
                    if ($urandom_range(0, 1) != 0) creg = 3;
                    if ($urandom_range(0, 1) != 0) areg = 2;
                end
                1: begin
                    cw  = $urandom_range(0, 4) == 0;
                    arw = $urandom_range(0, 4) != 0;
                    if ($urandom_range(0, 1) != 0) creg = 1;
                    if ($urandom_range(0, 1) != 0) areg = 1;
                end
                default: begin
                    cw  = $urandom_range(0, 1) != 0;
                    arw = $urandom_range(0, 1) != 0;
                end
            endcase
            init = $urandom_range(0, 149) == 0;
            step(cs, cw, cch, creg, 16'($urandom), as, arw, ach, areg, 8'($urandom), init);
        end

        // Asynchronous reset clears a pending interrupt without a clock edge
        idle();
        cwrt(0, 2, 16'h0040);
        idle();
        chk("pre_async_irq", {15'h0, last_req}, 16'h0001);
        #2 rst_n = 1'b0;
        #1;
        chk("async_irq_req", {15'h0, irq_req}, 16'h0);
        chk("async_irq_vec", {7'h0, irq_vec}, 16'h0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        crd(0, 2);
        chk("xcsr_after_async", last_cpu, 16'h0080);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
